// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests one ROM word at a time and presents it on a
// valid/ready interface, with redirect, stall timeout and a sticky error flag.
`timescale 1ns/1ps
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_cs,
  output logic [31:0] rom_addr,
  input  logic        rom_stall,
  input  logic [31:0] rom_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        fetch_err
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
  localparam logic [31:0] PC_RST = RESET_PC & ~32'h3;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          valid_q, valid_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   ifpc_q, ifpc_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    ifpc_d  = ifpc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (!rom_stall) begin
          inst_d  = rom_data;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_VAL) begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      HOLD: begin
        if (valid_q && if_ready) begin
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    // Redirect overrides capture, handshake and timeout decided above.
    if (redirect && state_q != IDLE) begin
      pc_d    = redirect_pc & ~32'h3;
      valid_d = 1'b0;
      inst_d  = inst_q;
      ifpc_d  = ifpc_q;
      err_d   = 1'b0;
      state_d = REQ;
    end

    if (state_d == REQ) begin
      cnt_d  = '0;
      addr_d = {2'b00, pc_d[31:2]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
      addr_q  <= {2'b00, PC_RST[31:2]};
      valid_q <= 1'b0;
      inst_q  <= '0;
      ifpc_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ifpc_q  <= ifpc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_cs    = (state_q == REQ) || (state_q == WAIT);
  assign rom_addr  = addr_q;
  assign if_valid  = valid_q;
  assign if_inst   = inst_q;
  assign if_pc     = ifpc_q;
  assign fetch_err = err_q;

endmodule
